noc_flit_rx_endpoint: RTL and testbench

Receive-side terminator of a credit-flow-controlled router link (data/dest/is_tail/send inbound, credit outbound). Buffers incoming flits, reassembles SER_FACTOR flits into one AXI-Stream beat, and drives an AXIS master toward a compute tile such as an MVM. It returns one credit per flit freed so the upstream transmitter's credit counter stays exact.

---
 rtl/noc_pkg.sv | 17 +
 rtl/noc_flit_fifo.sv | 65 ++++++
 rtl/noc_flit_rx_endpoint.sv | 146 ++++++++++++++
 tb/tb_noc_flit_rx_endpoint.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared defaults, the flit record and the SER_FACTOR legality check for the NoC receive endpoint.
package noc_pkg;

    localparam int FLIT_WIDTH_DEF = 32;
    localparam int DEST_WIDTH_DEF = 6;

    typedef struct packed {
        logic [FLIT_WIDTH_DEF-1:0] data;
        logic [DEST_WIDTH_DEF-1:0] dest;
        logic                      tail;
    } flit_t;

    function automatic bit ser_factor_ok(input int ser);
        return (ser == 1) || (ser == 2) || (ser == 4);
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Show-ahead synchronous FIFO; a write is accepted while full if a read retires an entry that same cycle.
module noc_flit_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 8,
    parameter int ADDRW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [ADDRW:0]   count
);

    localparam int CNTW = ADDRW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNTW'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + ADDRW'(do_wr);
        rd_ptr_d = rd_ptr_q + ADDRW'(do_rd);
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CNTW'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/noc_flit_rx_endpoint.sv
// Credit-flow receive endpoint: buffers flits, packs SER_FACTOR flits per AXIS beat and returns one credit per pop.
module noc_flit_rx_endpoint
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
    parameter int DEST_WIDTH = DEST_WIDTH_DEF,
    parameter int SER_FACTOR = 1,
    parameter int DATAW      = FLIT_WIDTH * SER_FACTOR,
    parameter int BUF_DEPTH  = 8,
    parameter int BUF_ADDRW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic                  axis_tx_tvalid,
    input  logic                  axis_tx_tready,
    output logic [DATAW-1:0]      axis_tx_tdata,
    output logic [DEST_WIDTH-1:0] axis_tx_tdest,
    output logic                  axis_tx_tlast,
    output logic [BUF_ADDRW:0]    occupancy,
    output logic                  err_overflow
);

    localparam int IDXW = (SER_FACTOR > 1) ? $clog2(SER_FACTOR) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SER_FACTOR - 1);

    if (!ser_factor_ok(SER_FACTOR)) begin : g_bad_ser
        $error("SER_FACTOR must be 1, 2 or 4");
    end

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } rx_flit_t;

    rx_flit_t in_flit, head;
    logic     fifo_full, fifo_empty, pop, out_free, completes;

    logic [DATAW-1:0]      merged;
    logic [DEST_WIDTH-1:0] beat_dest;

    logic [DATAW-1:0]      asm_data_q, asm_data_d;
    logic [DEST_WIDTH-1:0] asm_dest_q, asm_dest_d;
    logic [IDXW-1:0]       asm_idx_q, asm_idx_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATAW-1:0]      tdata_q, tdata_d;
    logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic                  tlast_q, tlast_d;
    logic                  credit_q, credit_d;
    logic                  err_q, err_d;

    assign in_flit = '{data: data_in, dest: dest_in, tail: is_tail_in};

    noc_flit_fifo #(
        .WIDTH ($bits(rx_flit_t)),
        .DEPTH (BUF_DEPTH),
        .ADDRW (BUF_ADDRW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (send_in),
        .wr_data (in_flit),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (occupancy)
    );

    // A completing flit goes straight into the output register, so it may only pop when that register frees up.
    always_comb begin
        out_free  = !tvalid_q || axis_tx_tready;
        completes = head.tail || (asm_idx_q == LAST_IDX);
        pop       = !fifo_empty && (!completes || out_free);

        merged = (asm_idx_q == '0) ? '0 : asm_data_q;
        for (int k = 0; k < SER_FACTOR; k++) begin
            if (asm_idx_q == IDXW'(k)) begin
                merged[k*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
            end
        end
        beat_dest = (asm_idx_q == '0) ? head.dest : asm_dest_q;

        asm_data_d = asm_data_q;
        asm_dest_d = asm_dest_q;
        asm_idx_d  = asm_idx_q;
        tvalid_d   = tvalid_q && !axis_tx_tready;
        tdata_d    = tdata_q;
        tdest_d    = tdest_q;
        tlast_d    = tlast_q;

        if (pop) begin
            if (completes) begin
                tvalid_d  = 1'b1;
                tdata_d   = merged;
                tdest_d   = beat_dest;
                tlast_d   = head.tail;
                asm_idx_d = '0;
            end else begin
                asm_data_d = merged;
                asm_dest_d = beat_dest;
                asm_idx_d  = asm_idx_q + IDXW'(1);
            end
        end

        credit_d = pop;
        err_d    = err_q || (send_in && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_data_q <= '0;
            asm_dest_q <= '0;
            asm_idx_q  <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tdest_q    <= '0;
            tlast_q    <= 1'b0;
            credit_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            asm_data_q <= asm_data_d;
            asm_dest_q <= asm_dest_d;
            asm_idx_q  <= asm_idx_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tdest_q    <= tdest_d;
            tlast_q    <= tlast_d;
            credit_q   <= credit_d;
            err_q      <= err_d;
        end
    end

    assign credit_out     = credit_q;
    assign axis_tx_tvalid = tvalid_q;
    assign axis_tx_tdata  = tdata_q;
    assign axis_tx_tdest  = tdest_q;
    assign axis_tx_tlast  = tlast_q;
    assign err_overflow   = err_q;

endmodule

// File: tb/tb_noc_flit_rx_endpoint.sv
// Scoreboard bench for noc_flit_rx_endpoint: one SER=1 instance and one SER=2 instance.
module tb_noc_flit_rx_endpoint;
    import noc_pkg::*;

    localparam int BD = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  dest;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] data1, data2;
    logic [5:0]  dest1, dest2;
    logic        tail1, tail2, send1, send2;
    logic        credit1, credit2;
    logic        tvalid1, tvalid2, tready1, tready2;
    logic [31:0] tdata1;
    logic [63:0] tdata2;
    logic [5:0]  tdest1, tdest2;
    logic        tlast1, tlast2;
    logic [3:0]  occ1, occ2;
    logic        err1, err2;

    int    total = 0;
    int    bad = 0;
    beat_t sb1[$];
    beat_t sb2[$];
    int    rd1 = 0, rd2 = 0;
    int    credits1 = 0, credits2 = 0;

    initial forever #5 clk = ~clk;

    noc_flit_rx_endpoint #(.SER_FACTOR(1), .BUF_DEPTH(BD), .BUF_ADDRW(3)) dut1 (
        .clk(clk), .rst(rst), .data_in(data1), .dest_in(dest1), .is_tail_in(tail1),
        .send_in(send1), .credit_out(credit1), .axis_tx_tvalid(tvalid1),
        .axis_tx_tready(tready1), .axis_tx_tdata(tdata1), .axis_tx_tdest(tdest1),
        .axis_tx_tlast(tlast1), .occupancy(occ1), .err_overflow(err1)
    );

    noc_flit_rx_endpoint #(.SER_FACTOR(2), .BUF_DEPTH(BD), .BUF_ADDRW(3)) dut2 (
        .clk(clk), .rst(rst), .data_in(data2), .dest_in(dest2), .is_tail_in(tail2),
        .send_in(send2), .credit_out(credit2), .axis_tx_tvalid(tvalid2),
        .axis_tx_tready(tready2), .axis_tx_tdata(tdata2), .axis_tx_tdest(tdest2),
        .axis_tx_tlast(tlast2), .occupancy(occ2), .err_overflow(err2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumes SER=1 beats against the scoreboard and checks AXIS hold under backpressure.
    task automatic mon1();
        logic        hold;
        logic [38:0] held;
        beat_t       e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("d1_hold", 64'({tvalid1, tdata1, tdest1, tlast1}), 64'({1'b1, held}));
                end
                if (tvalid1 && tready1) begin
                    if (rd1 < sb1.size()) begin
                        e = sb1[rd1];
                        rd1++;
                        check("d1_tdata", 64'(tdata1), e.data);
                        check("d1_tdest", 64'(tdest1), 64'(e.dest));
                        check("d1_tlast", 64'(tlast1), 64'(e.last));
                    end else begin
                        check("d1_extra_beat", 64'(tvalid1), 64'd0);
                    end
                end
                hold = tvalid1 && !tready1;
                held = {tdata1, tdest1, tlast1};
                if (credit1) credits1++;
            end
        end
    endtask

    task automatic mon2();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tvalid2 && tready2) begin
                    if (rd2 < sb2.size()) begin
                        e = sb2[rd2];
                        rd2++;
                        check("d2_tdata", tdata2, e.data);
                        check("d2_tdest", 64'(tdest2), 64'(e.dest));
                        check("d2_tlast", 64'(tlast2), 64'(e.last));
                    end else begin
                        check("d2_extra_beat", 64'(tvalid2), 64'd0);
                    end
                end
                if (credit2) credits2++;
            end
        end
    endtask

    task automatic drive1(input flit_t f, input bit expect_beat);
        send1 = 1'b1;
        data1 = f.data;
        dest1 = f.dest;
        tail1 = f.tail;
        if (expect_beat) sb1.push_back('{data: 64'(f.data), dest: f.dest, last: f.tail});
        tick();
        send1 = 1'b0;
    endtask

    task automatic drive2(input logic [31:0] d, input logic [5:0] dst, input logic t);
        send2 = 1'b1;
        data2 = d;
        dest2 = dst;
        tail2 = t;
        tick();
        send2 = 1'b0;
    endtask

    task automatic drain1(input int limit);
        for (int i = 0; i < limit && rd1 < sb1.size(); i++) tick();
        check("d1_drain", 64'(rd1), 64'(sb1.size()));
    endtask

    task automatic drain2(input int limit);
        for (int i = 0; i < limit && rd2 < sb2.size(); i++) tick();
        check("d2_drain", 64'(rd2), 64'(sb2.size()));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int    base, cr, sent, cyc;
        flit_t f;

        rst = 1'b1;
        {data1, dest1, tail1, send1, tready1} = '0;
        {data2, dest2, tail2, send2, tready2} = '0;
        fork
            mon1();
            mon2();
        join_none
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 64'(tvalid1), 64'd0);
        check("rst_tdata", 64'(tdata1), 64'd0);
        check("rst_occ", 64'(occ1), 64'd0);
        check("rst_credit", 64'(credit1), 64'd0);
        check("rst_err", 64'(err1), 64'd0);
        check("rst_tvalid2", 64'(tvalid2), 64'd0);

        // Single flit latency and credit timing
        tick();
        tready1 = 1'b1;
        base = credits1;
        drive1('{data: 32'hDEADBEEF, dest: 6'd5, tail: 1'b1}, 1'b1);
        @(negedge clk);
        check("t1_c1_tvalid", 64'(tvalid1), 64'd0);
        check("t1_c1_credit", 64'(credit1), 64'd0);
        tick();
        @(negedge clk);
        check("t1_c2_tvalid", 64'(tvalid1), 64'd1);
        check("t1_c2_tdata", 64'(tdata1), 64'hDEADBEEF);
        check("t1_c2_tdest", 64'(tdest1), 64'd5);
        check("t1_c2_tlast", 64'(tlast1), 64'd1);
        check("t1_c2_credit", 64'(credit1), 64'd1);
        tick();
        @(negedge clk);
        check("t1_c3_credit", 64'(credit1), 64'd0);
        check("t1_c3_tvalid", 64'(tvalid1), 64'd0);
        check("t1_credits", 64'(credits1 - base), 64'd1);

        // Fill under backpressure, overflow, then release
        tick();
        tready1 = 1'b0;
        base = credits1;
        for (int i = 0; i < 9; i++) begin
            drive1('{data: 32'hA000_0000 + 32'(i), dest: 6'(i + 1), tail: 1'b0}, 1'b1);
        end
        tick();
        tick();
        @(negedge clk);
        check("t2_occ_full", 64'(occ1), 64'd8);
        check("t2_err_clear", 64'(err1), 64'd0);
        check("t2_tvalid_held", 64'(tvalid1), 64'd1);
        tick();
        drive1('{data: 32'hBAD0_0000, dest: 6'd63, tail: 1'b1}, 1'b0);
        @(negedge clk);
        check("t2_err_set", 64'(err1), 64'd1);
        check("t2_occ_after_drop", 64'(occ1), 64'd8);
        tick();
        tready1 = 1'b1;
        drain1(60);
        tick();
        tick();
        check("t2_credits", 64'(credits1 - base), 64'd9);
        check("t2_occ_empty", 64'(occ1), 64'd0);

        // SER=2: full beat, short beat, then fresh packets from index 0
        tready2 = 1'b1;
        base = credits2;
        sb2.push_back('{data: 64'h22222222_11111111, dest: 6'd3, last: 1'b1});
        drive2(32'h11111111, 6'd3, 1'b0);
        drive2(32'h22222222, 6'd7, 1'b1);
        sb2.push_back('{data: 64'h00000000_0000AAAA, dest: 6'd9, last: 1'b1});
        drive2(32'h0000AAAA, 6'd9, 1'b1);
        sb2.push_back('{data: 64'h44444444_33333333, dest: 6'd10, last: 1'b1});
        drive2(32'h33333333, 6'd10, 1'b0);
        drive2(32'h44444444, 6'd11, 1'b1);
        sb2.push_back('{data: 64'h66666666_55555555, dest: 6'd12, last: 1'b0});
        sb2.push_back('{data: 64'h00000000_77777777, dest: 6'd14, last: 1'b1});
        drive2(32'h55555555, 6'd12, 1'b0);
        drive2(32'h66666666, 6'd13, 1'b0);
        drive2(32'h77777777, 6'd14, 1'b1);
        drain2(40);
        tick();
        tick();
        check("t3_credits2", 64'(credits2 - base), 64'd8);
        check("t3_err2", 64'(err2), 64'd0);

        // Reset mid-stream discards buffered flits without credits
        do_reset();
        @(negedge clk);
        check("t5_err_cleared", 64'(err1), 64'd0);
        tick();
        tready1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive1('{data: 32'hB000_0000 + 32'(i), dest: 6'd2, tail: 1'b1}, 1'b0);
        end
        tick();
        tick();
        @(negedge clk);
        check("t5_occ3", 64'(occ1), 64'd3);
        check("t5_tvalid_held", 64'(tvalid1), 64'd1);
        tick();
        base = credits1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_tvalid_rst", 64'(tvalid1), 64'd0);
        check("t5_occ_rst", 64'(occ1), 64'd0);
        check("t5_credit_rst", 64'(credit1), 64'd0);
        tick();
        tick();
        tick();
        check("t5_no_credits", 64'(credits1 - base), 64'd0);
        tready1 = 1'b1;
        drive1('{data: 32'hC0FFEE01, dest: 6'd21, tail: 1'b1}, 1'b1);
        drain1(20);

        // Random traffic with a credit-respecting sender
        do_reset();
        base = credits1;
        cr = BD;
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            if (credit1) cr++;
            tready1 = ($urandom_range(0, 3) != 0);
            if (cr > 0 && $urandom_range(0, 4) != 0) begin
                f.data = $urandom;
                f.dest = 6'($urandom_range(0, 63));
                f.tail = 1'($urandom_range(0, 1));
                cr--;
                sent++;
                drive1(f, 1'b1);
            end else begin
                tick();
            end
            cyc++;
        end
        check("t6_sent", 64'(sent), 64'd1000);
        tready1 = 1'b1;
        drain1(200);
        tick();
        tick();
        tick();
        check("t6_credits", 64'(credits1 - base), 64'd1000);
        check("t6_err", 64'(err1), 64'd0);
        check("t6_occ", 64'(occ1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
